// File: rtl/warships_pkg.sv
// warships_pkg: shared cell status codes, command op codes, FSM states and grid defaults
package warships_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_MYSHIP = 2'b01,
    ST_MISS   = 2'b10,
    ST_HIT    = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_PLACE = 2'b01,
    OP_SHOOT = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_CLEAR = 2'b00,
    S_IDLE  = 2'b01,
    S_RD    = 2'b10,
    S_EXEC  = 2'b11
  } state_e;

  localparam int unsigned DEF_GRID_COLS = 12;
  localparam int unsigned DEF_GRID_ROWS = 12;

  // true when (x,y) lies inside a cols x rows grid
  function automatic logic in_grid(input logic [3:0] x, input logic [3:0] y,
                                   input int unsigned cols, input int unsigned rows);
    return (32'(x) < cols) && (32'(y) < rows);
  endfunction

endpackage

// File: rtl/board_ram.sv
// board_ram: 256x2 storage, read-only port A and read/write port B, both registered read-first
module board_ram (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a_addr,
  output logic [1:0] a_rdata,
  input  logic [7:0] b_addr,
  input  logic       b_we,
  input  logic [1:0] b_wdata,
  output logic [1:0] b_rdata
);

  logic [1:0] mem [256];
  logic [1:0] a_q, b_q;

  // array write; contents are initialised by the owner's clear sweep, not by reset
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
  end

  // registered reads sample the pre-write contents, giving read-first behaviour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 2'b00;
      b_q <= 2'b00;
    end else begin
      a_q <= mem[a_addr];
      b_q <= mem[b_addr];
    end
  end

  assign a_rdata = a_q;
  assign b_rdata = b_q;

endmodule

// File: rtl/board_mem.sv
// board_mem: per-player board store with PLACE/SHOOT/CLEAR command FSM, ship counter and draw read port; BOARD_MEM_FOG_EN hides MYSHIP cells on rd_status
module board_mem
  import warships_pkg::*;
#(
  parameter int unsigned GRID_COLS = DEF_GRID_COLS,
  parameter int unsigned GRID_ROWS = DEF_GRID_ROWS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rd_addr,
  output logic [1:0] rd_status,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  output logic       resp_valid,
  output logic [1:0] resp_status,
  output logic       resp_err,
  output logic [7:0] ships_left,
  output logic       all_sunk,
  output logic       clearing
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ships_q, ships_d;
  logic       sunk_q, sunk_d;
  logic       clr_cmd_q, clr_cmd_d;
  logic [3:0] x_q, x_d, y_q, y_d;
  logic [1:0] op_q, op_d;
  logic       rv_q, rv_d, re_q, re_d;
  logic [1:0] rs_q, rs_d;
  logic       rd_ok_q;
  logic       we;
  logic [1:0] wdata, a_rdata, b_rdata, rd_view;
  logic [7:0] b_addr;
  logic       accept, tgt_ok;

  assign cmd_ready = state_q == S_IDLE;
  assign clearing  = state_q == S_CLEAR;
  assign accept    = cmd_valid && cmd_ready;
  assign tgt_ok    = in_grid(x_q, y_q, GRID_COLS, GRID_ROWS);
  assign b_addr    = clearing ? cnt_q : {x_q, y_q};

  board_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_addr  (rd_addr),
    .a_rdata (a_rdata),
    .b_addr  (b_addr),
    .b_we    (we),
    .b_wdata (wdata),
    .b_rdata (b_rdata)
  );

  // next-state, write strobe, counters and response for the clear/command FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ships_d   = ships_q;
    sunk_d    = sunk_q;
    clr_cmd_d = clr_cmd_q;
    x_d       = x_q;
    y_d       = y_q;
    op_d      = op_q;
    rv_d      = 1'b0;
    re_d      = re_q;
    rs_d      = rs_q;
    we        = 1'b0;
    wdata     = ST_EMPTY;
    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'hff) begin
          state_d   = S_IDLE;
          clr_cmd_d = 1'b0;
          rv_d      = clr_cmd_q;
          re_d      = clr_cmd_q ? 1'b0 : re_q;
          rs_d      = clr_cmd_q ? ST_EMPTY : rs_q;
        end
      end
      S_IDLE: begin
        if (accept) begin
          x_d  = cmd_x;
          y_d  = cmd_y;
          op_d = cmd_op;
          if (cmd_op == OP_CLEAR) begin
            state_d   = S_CLEAR;
            cnt_d     = 8'd0;
            ships_d   = 8'd0;
            sunk_d    = 1'b0;
            clr_cmd_d = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_EXEC;
      default: begin
        state_d = S_IDLE;
        rv_d    = 1'b1;
        re_d    = 1'b1;
        rs_d    = ST_EMPTY;
        if (tgt_ok && op_q == OP_PLACE) begin
          rs_d = (b_rdata == ST_EMPTY) ? ST_MYSHIP : b_rdata;
          if (b_rdata == ST_EMPTY) begin
            we      = 1'b1;
            wdata   = ST_MYSHIP;
            re_d    = 1'b0;
            ships_d = (ships_q == 8'hff) ? ships_q : ships_q + 8'd1;
          end
        end else if (tgt_ok && op_q == OP_SHOOT) begin
          rs_d = b_rdata;
          if (b_rdata == ST_EMPTY) begin
            we    = 1'b1;
            wdata = ST_MISS;
            re_d  = 1'b0;
            rs_d  = ST_MISS;
          end else if (b_rdata == ST_MYSHIP) begin
            we      = 1'b1;
            wdata   = ST_HIT;
            re_d    = 1'b0;
            rs_d    = ST_HIT;
            sunk_d  = 1'b1;
            ships_d = (ships_q == 8'h00) ? ships_q : ships_q - 8'd1;
          end
        end
      end
    endcase
  end

  // state, latched command, counters and response registers; reset restarts the sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      cnt_q     <= 8'd0;
      ships_q   <= 8'd0;
      sunk_q    <= 1'b0;
      clr_cmd_q <= 1'b0;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      op_q      <= OP_NOP;
      rv_q      <= 1'b0;
      re_q      <= 1'b0;
      rs_q      <= ST_EMPTY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ships_q   <= ships_d;
      sunk_q    <= sunk_d;
      clr_cmd_q <= clr_cmd_d;
      x_q       <= x_d;
      y_q       <= y_d;
      op_q      <= op_d;
      rv_q      <= rv_d;
      re_q      <= re_d;
      rs_q      <= rs_d;
    end
  end

  // qualifies the draw read: off-grid or mid-sweep samples are reported as EMPTY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ok_q <= 1'b0;
    else        rd_ok_q <= in_grid(rd_addr[7:4], rd_addr[3:0], GRID_COLS, GRID_ROWS) && !clearing;
  end

`ifdef BOARD_MEM_FOG_EN
  assign rd_view = (a_rdata == ST_MYSHIP) ? ST_EMPTY : a_rdata;
`else
  assign rd_view = a_rdata;
`endif

  assign rd_status   = (clearing || !rd_ok_q) ? ST_EMPTY : rd_view;
  assign resp_valid  = rv_q;
  assign resp_status = rs_q;
  assign resp_err    = re_q;
  assign ships_left  = ships_q;
  assign all_sunk    = sunk_q && (ships_q == 8'd0);

endmodule

// File: tb/tb_board_mem.sv
// tb_board_mem: directed self-checking bench for board_mem
module tb_board_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [1:0] rd_status;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_x = 4'd0;
  logic [3:0] cmd_y = 4'd0;
  logic       resp_valid;
  logic [1:0] resp_status;
  logic       resp_err;
  logic [7:0] ships_left;
  logic       all_sunk;
  logic       clearing;

  int errors = 0;
  int checks = 0;

  board_mem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_status   (rd_status),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .resp_valid  (resp_valid),
    .resp_status (resp_status),
    .resp_err    (resp_err),
    .ships_left  (ships_left),
    .all_sunk    (all_sunk),
    .clearing    (clearing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // from a negedge just after reset release or a CLEAR accept: sweep length, no ready, no response
  task automatic wait_sweep(input string tag, input int exp_n);
    int n = 0;
    logic bad_ready = 1'b0;
    logic saw_resp = 1'b0;
    while (clearing && n < 400) begin
      if (cmd_ready) bad_ready = 1'b1;
      if (resp_valid) saw_resp = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_len"}, n, exp_n);
    chk({tag, "_ready_in_sweep"}, bad_ready, 0);
    chk({tag, "_no_resp"}, saw_resp | resp_valid, 0);
    chk({tag, "_ready_after"}, cmd_ready, 1);
  endtask

  // issue one command at a negedge in IDLE and check the response strobe
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                        input logic [1:0] es, input logic ee);
    int lat = 1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_x = x;
    cmd_y = y;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_status"}, resp_status, es);
    chk({tag, "_err"}, resp_err, ee);
    chk({tag, "_ready"}, cmd_ready, 1);
  endtask

  initial begin
    logic [1:0] fog_exp;
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_clearing", clearing, 1);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_ships", ships_left, 0);
    chk("rst_all_sunk", all_sunk, 0);
    chk("rst_rd_status", rd_status, 0);
    rst_n = 1'b1;
    wait_sweep("init_sweep", 256);
    rd_addr = 8'h00;
    @(negedge clk);
    chk("rd_00_after_sweep", rd_status, 0);

    do_cmd("place35", 2'b01, 4'd3, 4'd5, 2'b01, 1'b0);
    chk("place35_ships", ships_left, 1);
    chk("place35_all_sunk", all_sunk, 0);
    rd_addr = 8'h35;
    @(negedge clk);
    chk("place35_single_pulse", resp_valid, 0);
    chk("rd_35_ship", rd_status, 2'b01);

    do_cmd("place35_again", 2'b01, 4'd3, 4'd5, 2'b01, 1'b1);
    chk("place35_again_ships", ships_left, 1);

    do_cmd("shoot35", 2'b10, 4'd3, 4'd5, 2'b11, 1'b0);
    chk("shoot35_ships", ships_left, 0);
    chk("shoot35_all_sunk", all_sunk, 1);
    chk("rd_35_read_first", rd_status, 2'b01);
    @(negedge clk);
    chk("rd_35_hit", rd_status, 2'b11);

    do_cmd("shoot35_again", 2'b10, 4'd3, 4'd5, 2'b11, 1'b1);
    chk("shoot35_again_all_sunk", all_sunk, 1);
    do_cmd("shoot00", 2'b10, 4'd0, 4'd0, 2'b10, 1'b0);
    chk("shoot00_ships", ships_left, 0);
    do_cmd("shoot_c0", 2'b10, 4'd12, 4'd0, 2'b00, 1'b1);
    chk("shoot_c0_ships", ships_left, 0);
    chk("shoot_c0_all_sunk", all_sunk, 1);
    do_cmd("nop", 2'b00, 4'd1, 4'd1, 2'b00, 1'b1);
    rd_addr = 8'hC0;
    @(negedge clk);
    chk("rd_c0_oob", rd_status, 0);
    rd_addr = 8'h00;
    @(negedge clk);
    chk("rd_00_miss", rd_status, 2'b10);

    do_cmd("place01", 2'b01, 4'd0, 4'd1, 2'b01, 1'b0);
    do_cmd("place11", 2'b01, 4'd1, 4'd1, 2'b01, 1'b0);
    do_cmd("place22", 2'b01, 4'd2, 4'd2, 2'b01, 1'b0);
    do_cmd("placebb", 2'b01, 4'd11, 4'd11, 2'b01, 1'b0);
    do_cmd("place0c", 2'b01, 4'd0, 4'd12, 2'b00, 1'b1);
    do_cmd("place44", 2'b01, 4'd4, 4'd4, 2'b01, 1'b0);
    chk("five_ships", ships_left, 5);
    chk("five_all_sunk", all_sunk, 0);

    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("clear_ships_now", ships_left, 0);
    chk("clear_all_sunk_now", all_sunk, 0);
    chk("clear_clearing", clearing, 1);
    lat = 1;
    while (!resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("clear_lat", lat, 257);
    chk("clear_status", resp_status, 0);
    chk("clear_err", resp_err, 0);
    chk("clear_done", clearing, 0);
    rd_addr = 8'h35;
    @(negedge clk);
    chk("rd_35_cleared", rd_status, 0);
    do_cmd("place11_post_clear", 2'b01, 4'd1, 4'd1, 2'b01, 1'b0);
    chk("post_clear_ships", ships_left, 1);

    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_clearing", clearing, 1);
    chk("midrst_ready", cmd_ready, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_ships", ships_left, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("midrst_sweep", 256);

    do_cmd("fog_place11", 2'b01, 4'd1, 4'd1, 2'b01, 1'b0);
    rd_addr = 8'h11;
    @(negedge clk);
`ifdef BOARD_MEM_FOG_EN
    fog_exp = 2'b00;
`else
    fog_exp = 2'b01;
`endif
    chk("rd_11_view", rd_status, fog_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
